fsk_rx_controller: RTL and testbench
====================================

// Module: fsk_rx_controller
// PURPOSE
//   Sequences the FSK receive path: calibrates the slicing threshold from ADC samples, runs the zero-crossing bit
//   slicer per bit window, hunts for a sync word, then delivers a fixed-length frame as bytes over valid/ready.
//   Sits between the 8-bit ADC sample stream and the packet consumer; replaces fixed THRESHOLD/window tuning.
// PARAMETERS
//   SAMPLES_PER_BIT  16     valid samples per bit window (>=2)
//   CAL_SAMPLES      256    valid samples observed during calibration (>=1)
//   HYST             4      hysteresis added/subtracted around threshold, 8-bit
//   XING_THRESH      4      crossings per window at or above which the bit is 1
//   SYNC_WORD        8'hD3  sync pattern, compared MSB-first on last 8 sliced bits
//   FRAME_BYTES      4      payload bytes per frame after sync (1..255)
// PORTS
//   clk         in   1  system clock
//   rst_n       in   1  synchronous reset, active-low
//   start       in   1  pulse: begin calibration (honoured only in IDLE)
//   abort       in   1  pulse: return to IDLE from any state
//   ad_data     in   8  unsigned ADC sample
//   ad_valid    in   1  ad_data qualifier; all counters advance only on valid samples
//   byte_data   out  8  received payload byte, MSB-first assembly
//   byte_valid  out  1  byte_data valid; held until byte_ready
//   byte_ready  in   1  consumer accept
//   thr_out     out  8  current slicing threshold
//   state_out   out  2  IDLE=0, CALIB=1, HUNT=2, DATA=3
//   frame_done  out  1  one-cycle pulse after last payload byte is captured
//   cal_fail    out  1  one-cycle pulse: signal swing too small
//   overrun     out  1  one-cycle pulse: byte completed while byte_valid still high
// BEHAVIOUR
//   Reset (rst_n=0 at clk edge): state IDLE; all outputs 0; thr_out=8'd128; min=255, max=0; counters cleared.
//   IDLE: start=1 -> CALIB next cycle, min/max reset to 255/0, cal counter 0.
//   CALIB: per valid sample update min/max (sample counted in same cycle). On CAL_SAMPLES-th sample:
//     sum 9-bit, thr=(min+max)>>1. If (max-min) <= 2*HYST: cal_fail pulse, thr_out unchanged, -> IDLE.
//     Else thr_out<=thr, slicer state cleared, -> HUNT.
//   Slicer (HUNT/DATA): hi=min(thr+HYST,255), lo=max(thr-HYST,0) (saturating, 9-bit intermediate).
//     Crossing = prev<lo & cur>hi & lvl==0 (lvl<=1), or prev>hi & cur<lo & lvl==1 (lvl<=0).
//     Window counter 0..SAMPLES_PER_BIT-1 on valid samples; on last sample bit=(xcnt+xing_now)>=XING_THRESH,
//     xcnt cleared same cycle; crossing counter saturates at 255. prev sample updates every valid sample.
//   HUNT: bit shifted into 8-bit shreg LSB; when shreg==SYNC_WORD (incl. bit just sliced) -> DATA next cycle,
//     byte count and bit count cleared, shreg cleared.
//   DATA: bits assembled MSB-first; 8th bit completes byte. If byte_valid=0 or byte_ready=1 that cycle:
//     load byte_data, byte_valid=1. Else overrun pulse, new byte dropped, old byte held. Dropped bytes still count.
//     After FRAME_BYTES-th byte: frame_done pulse same cycle as capture, -> HUNT; thr_out retained.
//   Handshake: byte_valid falls cycle after byte_valid&byte_ready unless a new byte loads simultaneously.
//   abort (any state, priority over start and sample events): -> IDLE next cycle, byte_valid=0, counters cleared,
//     thr_out retained. start outside IDLE ignored. rst_n takes priority over everything.
//   ad_valid=0: no counter, min/max, prev-sample or shreg change; handshake still proceeds.
// TESTING
//   Cal: start, 256 samples alternating 20/200 -> thr_out=110, state HUNT, no cal_fail.
//   Flat: start, 256 samples of 100 -> cal_fail pulse, thr_out stays 128, state IDLE.
//   Sync: after cal, send 0xD3 as bits (1: square 20/200 period 4, 0: constant 20) -> state DATA after 8th bit.
//   Frame: sync then 0xA5,0x3C,0xFF,0x00, byte_ready=1 -> 4 byte_valid beats in order, frame_done, state HUNT.
//   Overrun: byte_ready=0 whole frame -> byte_data=0xA5 held, 3 overrun pulses, frame_done still pulses.
//   Abort mid-DATA after 2 bytes -> state IDLE next cycle, byte_valid=0, thr_out=110; rst_n=0 -> all reset values.

Source files
------------

// File: rtl/fsk_rx_if.sv
// Signal bundle between the FSK receive controller and its environment:
// sample stream in, control pulses in, payload bytes and status out.
interface fsk_rx_if;
  logic       start;
  logic       abort;
  logic [7:0] ad_data;
  logic       ad_valid;
  logic [7:0] byte_data;
  logic       byte_valid;
  logic       byte_ready;
  logic [7:0] thr_out;
  logic [1:0] state_out;
  logic       frame_done;
  logic       cal_fail;
  logic       overrun;

  modport master (
    output start, abort, ad_data, ad_valid, byte_ready,
    input  byte_data, byte_valid, thr_out, state_out, frame_done, cal_fail, overrun
  );

  modport slave (
    input  start, abort, ad_data, ad_valid, byte_ready,
    output byte_data, byte_valid, thr_out, state_out, frame_done, cal_fail, overrun
  );
endinterface

// File: rtl/fsk_rx_controller.sv
// FSK receive sequencer: threshold calibration from min/max of the ADC stream,
// hysteresis zero-crossing bit slicer, sync-word hunt and fixed-length byte framing.
module fsk_rx_controller #(
  parameter int         SAMPLES_PER_BIT = 16,
  parameter int         CAL_SAMPLES     = 256,
  parameter logic [7:0] HYST            = 8'd4,
  parameter int         XING_THRESH     = 4,
  parameter logic [7:0] SYNC_WORD       = 8'hD3,
  parameter int         FRAME_BYTES     = 4
) (
  input logic     clk,
  input logic     rst_n,
  fsk_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CALIB = 2'd1,
    HUNT  = 2'd2,
    DATA  = 2'd3
  } state_t;

  localparam int CAL_W = $clog2(CAL_SAMPLES + 1);
  localparam int WIN_W = $clog2(SAMPLES_PER_BIT);
  localparam logic [CAL_W-1:0] CAL_LAST   = CAL_W'(CAL_SAMPLES - 1);
  localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(SAMPLES_PER_BIT - 1);
  localparam logic [7:0]       BYTES_LAST = 8'(FRAME_BYTES - 1);

  state_t state, state_next;

  logic [7:0]       thr, min_r, max_r, prev, xcnt, shreg, byte_sh, byte_cnt, byte_data_r;
  logic             lvl, byte_valid_r, frame_done_r, cal_fail_r, overrun_r;
  logic [CAL_W-1:0] cal_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [2:0]       bit_cnt;

  logic [7:0] cur, min_new, max_new, thr_cal, hi, lo, byte_word;
  logic [8:0] swing, hi_sum, lo_dif, xsum;
  logic       cal_last, cal_bad, xing_up, xing_dn, bit_val, bit_evt;
  logic       sync_hit, byte_evt, byte_load, frame_end;

  assign cur     = bus.ad_data;
  assign min_new = (cur < min_r) ? cur : min_r;
  assign max_new = (cur > max_r) ? cur : max_r;
  assign thr_cal = 8'(({1'b0, min_new} + {1'b0, max_new}) >> 1);
  assign swing   = {1'b0, max_new} - {1'b0, min_new};
  assign cal_last = (state == CALIB) && bus.ad_valid && (cal_cnt == CAL_LAST);
  assign cal_bad  = swing <= {HYST, 1'b0};

  // Hysteresis band around the threshold, clamped to the 8-bit sample range.
  assign hi_sum = {1'b0, thr} + {1'b0, HYST};
  assign lo_dif = {1'b0, thr} - {1'b0, HYST};
  assign hi     = hi_sum[8] ? 8'hFF : hi_sum[7:0];
  assign lo     = lo_dif[8] ? 8'h00 : lo_dif[7:0];

  assign xing_up = !lvl && (prev < lo) && (cur > hi);
  assign xing_dn =  lvl && (prev > hi) && (cur < lo);
  assign xsum    = {1'b0, xcnt} + {8'd0, xing_up | xing_dn};
  assign bit_val = xsum >= 9'(XING_THRESH);
  assign bit_evt = ((state == HUNT) || (state == DATA)) && bus.ad_valid && (win_cnt == WIN_LAST);

  assign sync_hit  = (state == HUNT) && bit_evt && ({shreg[6:0], bit_val} == SYNC_WORD);
  assign byte_evt  = (state == DATA) && bit_evt && (bit_cnt == 3'd7);
  assign byte_word = {byte_sh[6:0], bit_val};
  assign frame_end = byte_evt && (byte_cnt == BYTES_LAST);

  // Output handshake: byte_valid rises when a byte is loaded and stays high with
  // byte_data stable until a cycle where byte_ready is also high; that cycle is the
  // transfer. A byte may load in the same cycle as a transfer, keeping valid high.
  assign byte_load = byte_evt && (!byte_valid_r || bus.byte_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.start) state_next = CALIB;
        CALIB:   if (cal_last)  state_next = cal_bad ? IDLE : HUNT;
        HUNT:    if (sync_hit)  state_next = DATA;
        DATA:    if (frame_end) state_next = HUNT;
        default: state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr          <= 8'd128;
      min_r        <= 8'hFF;
      max_r        <= 8'h00;
      cal_cnt      <= '0;
      win_cnt      <= '0;
      xcnt         <= '0;
      prev         <= '0;
      lvl          <= 1'b0;
      shreg        <= '0;
      byte_sh      <= '0;
      bit_cnt      <= '0;
      byte_cnt     <= '0;
      byte_data_r  <= '0;
      byte_valid_r <= 1'b0;
      frame_done_r <= 1'b0;
      cal_fail_r   <= 1'b0;
      overrun_r    <= 1'b0;
    end else begin
      frame_done_r <= 1'b0;
      cal_fail_r   <= 1'b0;
      overrun_r    <= 1'b0;
      if (byte_valid_r && bus.byte_ready) byte_valid_r <= 1'b0;

      if (bus.abort) begin
        byte_valid_r <= 1'b0;
        cal_cnt      <= '0;
        win_cnt      <= '0;
        xcnt         <= '0;
        prev         <= '0;
        lvl          <= 1'b0;
        shreg        <= '0;
        byte_sh      <= '0;
        bit_cnt      <= '0;
        byte_cnt     <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              min_r   <= 8'hFF;
              max_r   <= 8'h00;
              cal_cnt <= '0;
            end
          end
          CALIB: begin
            if (bus.ad_valid) begin
              min_r <= min_new;
              max_r <= max_new;
              if (cal_cnt == CAL_LAST) begin
                cal_cnt <= '0;
                if (cal_bad) begin
                  cal_fail_r <= 1'b1;
                end else begin
                  thr     <= thr_cal;
                  win_cnt <= '0;
                  xcnt    <= '0;
                  prev    <= '0;
                  lvl     <= 1'b0;
                  shreg   <= '0;
                end
              end else begin
                cal_cnt <= cal_cnt + CAL_W'(1);
              end
            end
          end
          HUNT, DATA: begin
            if (bus.ad_valid) begin
              prev <= cur;
              if (xing_up)      lvl <= 1'b1;
              else if (xing_dn) lvl <= 1'b0;
              if (bit_evt) begin
                win_cnt <= '0;
                xcnt    <= '0;
              end else begin
                win_cnt <= win_cnt + WIN_W'(1);
                xcnt    <= xsum[8] ? 8'hFF : xsum[7:0];
              end

              if (bit_evt && (state == HUNT)) begin
                if (sync_hit) begin
                  shreg    <= '0;
                  byte_sh  <= '0;
                  bit_cnt  <= '0;
                  byte_cnt <= '0;
                end else begin
                  shreg <= {shreg[6:0], bit_val};
                end
              end

              // Bytes dropped on overrun still count toward the frame length.
              if (bit_evt && (state == DATA)) begin
                byte_sh <= byte_word;
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_evt) begin
                  byte_cnt <= byte_cnt + 8'd1;
                  if (byte_load) begin
                    byte_data_r  <= byte_word;
                    byte_valid_r <= 1'b1;
                  end else begin
                    overrun_r <= 1'b1;
                  end
                  if (frame_end) begin
                    frame_done_r <= 1'b1;
                    byte_cnt     <= '0;
                  end
                end
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.byte_data  = byte_data_r;
  assign bus.byte_valid = byte_valid_r;
  assign bus.thr_out    = thr;
  assign bus.state_out  = state;
  assign bus.frame_done = frame_done_r;
  assign bus.cal_fail   = cal_fail_r;
  assign bus.overrun    = overrun_r;

endmodule

// File: tb/tb_fsk_rx_controller.sv
// Bench for fsk_rx_controller: randomized sample streams checked every cycle against
// a window/frame-level behavioural model of calibration, slicing and framing.
module tb_fsk_rx_controller;
  localparam int         SPB  = 16;
  localparam int         CALN = 256;
  localparam int         HYST = 4;
  localparam int         XTH  = 4;
  localparam int         FB   = 4;
  localparam logic [7:0] SYNC = 8'hD3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fsk_rx_if bus();

  fsk_rx_controller #(
    .SAMPLES_PER_BIT(SPB),
    .CAL_SAMPLES    (CALN),
    .HYST           (8'(HYST)),
    .XING_THRESH    (XTH),
    .SYNC_WORD      (SYNC),
    .FRAME_BYTES    (FB)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [7:0] exp_q[$];
  int         cal_q[$];

  int   model_st  = 0;
  int   model_thr = 128;
  logic model_bv  = 1'b0;
  logic load_pending = 1'b0;
  logic exp_fd = 1'b0, exp_ov = 1'b0, exp_cf = 1'b0;

  int         m_prev = 0, m_win = 0, m_x = 0, m_nbits = 0, m_nbytes = 0;
  logic       m_lvl = 1'b0;
  logic [7:0] m_hist = 8'd0, m_byte = 8'd0;

  int n_fd = 0, n_ov = 0, n_cf = 0;
  int ready_mode = 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- clock/cycle block ----------------
  task automatic tick();
    logic       acc;
    logic [7:0] pd;
    acc = model_bv && (bus.byte_ready === 1'b1);
    pd  = bus.byte_data;
    @(posedge clk);
    #1;
    if (acc && exp_q.size() > 0) check_val("byte_data", 32'(pd), 32'(exp_q.pop_front()));
    if (!rst_n) begin
      model_st = 0; model_thr = 128; model_bv = 1'b0;
    end else if (bus.abort) begin
      model_st = 0; model_bv = 1'b0;
    end else if (load_pending) begin
      model_bv = 1'b1;
    end else if (acc) begin
      model_bv = 1'b0;
    end
    load_pending = 1'b0;
    check_val("byte_valid", 32'(bus.byte_valid), 32'(model_bv));
    check_val("state_out",  32'(bus.state_out),  32'(model_st));
    check_val("thr_out",    32'(bus.thr_out),    32'(model_thr));
    check_val("frame_done", 32'(bus.frame_done), 32'(exp_fd));
    check_val("overrun",    32'(bus.overrun),    32'(exp_ov));
    check_val("cal_fail",   32'(bus.cal_fail),   32'(exp_cf));
    if (bus.frame_done === 1'b1) n_fd++;
    if (bus.overrun === 1'b1)    n_ov++;
    if (bus.cal_fail === 1'b1)   n_cf++;
    exp_fd = 1'b0; exp_ov = 1'b0; exp_cf = 1'b0;
    if (ready_mode == 2) bus.byte_ready = 1'($urandom_range(0, 1));
  endtask

  // ---------------- reference model ----------------
  task automatic model_cal(input int s);
    int mn, mx;
    cal_q.push_back(s);
    if (cal_q.size() == CALN) begin
      mn = 255; mx = 0;
      foreach (cal_q[i]) begin
        if (cal_q[i] < mn) mn = cal_q[i];
        if (cal_q[i] > mx) mx = cal_q[i];
      end
      if (mx - mn <= 2 * HYST) begin
        exp_cf = 1'b1; model_st = 0;
      end else begin
        model_thr = (mn + mx) / 2; model_st = 2;
        m_prev = 0; m_lvl = 1'b0; m_win = 0; m_x = 0; m_hist = 8'd0;
      end
      cal_q.delete();
    end
  endtask

  task automatic model_bit(input logic b);
    if (model_st == 2) begin
      m_hist = {m_hist[6:0], b};
      if (m_hist == SYNC) begin
        model_st = 3; m_hist = 8'd0; m_nbits = 0; m_nbytes = 0;
      end
    end else begin
      m_byte = {m_byte[6:0], b};
      m_nbits++;
      if (m_nbits == 8) begin
        m_nbits = 0;
        m_nbytes++;
        if (!model_bv || bus.byte_ready === 1'b1) begin
          exp_q.push_back(m_byte);
          load_pending = 1'b1;
        end else begin
          exp_ov = 1'b1;
        end
        if (m_nbytes == FB) begin
          exp_fd = 1'b1; model_st = 2;
        end
      end
    end
  endtask

  task automatic model_slice(input int s);
    int hi, lo;
    hi = (model_thr + HYST > 255) ? 255 : model_thr + HYST;
    lo = (model_thr - HYST < 0) ? 0 : model_thr - HYST;
    if (!m_lvl && m_prev < lo && s > hi) begin
      m_lvl = 1'b1; m_x++;
    end else if (m_lvl && m_prev > hi && s < lo) begin
      m_lvl = 1'b0; m_x++;
    end
    m_prev = s;
    m_win++;
    if (m_win == SPB) begin
      m_win = 0;
      model_bit(m_x >= XTH);
      m_x = 0;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_sample(input logic [7:0] s);
    bus.ad_data  = s;
    bus.ad_valid = 1'b1;
    if (model_st == 1)      model_cal(int'(s));
    else if (model_st >= 2) model_slice(int'(s));
    tick();
    bus.ad_valid = 1'b0;
    bus.ad_data  = 8'($urandom);
    if ($urandom_range(0, 7) == 0) repeat ($urandom_range(1, 3)) tick();
  endtask

  task automatic idle_cycles(input int n);
    bus.ad_valid = 1'b0;
    repeat (n) tick();
  endtask

  // kind: 0 flat low, 1 flat high, 2 period-4 square, 3 period-8 square
  task automatic send_window(input int kind);
    logic [7:0] lv, hv, s;
    lv = 8'($urandom_range(0, 60));
    hv = 8'($urandom_range(170, 255));
    for (int k = 0; k < SPB; k++) begin
      case (kind)
        0:       s = lv;
        1:       s = hv;
        2:       s = (k % 4 < 2) ? lv : hv;
        default: s = (k % 8 < 4) ? lv : hv;
      endcase
      send_sample(s);
    end
  endtask

  task automatic send_bit(input logic b);
    if (b) send_window(2);
    else   send_window($urandom_range(0, 1));
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic do_start();
    bus.ad_valid = 1'b0;
    bus.start    = 1'b1;
    if (model_st == 0) begin
      model_st = 1; cal_q.delete();
    end
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_abort();
    bus.ad_valid = 1'b0;
    bus.abort    = 1'b1;
    tick();
    bus.abort = 1'b0;
    exp_q.delete();
    cal_q.delete();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bus.ad_valid = 1'b0;
    bus.start    = 1'b0;
    bus.abort    = 1'b0;
    repeat (2) tick();
    check_val("rst_byte_data", 32'(bus.byte_data), 32'd0);
    check_val("rst_thr",       32'(bus.thr_out),   32'd128);
    check_val("rst_state",     32'(bus.state_out), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    cal_q.delete();
    tick();
  endtask

  task automatic cal_standard();
    do_start();
    for (int i = 0; i < CALN; i++) send_sample((i % 2 == 1) ? 8'd200 : 8'd20);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd0, ov0, cf0, mn, mx, kind, p1, p2;
    logic [7:0] pay[4];
    logic [7:0] cal_s[CALN];
    bus.start = 1'b0; bus.abort = 1'b0; bus.ad_data = 8'd0; bus.ad_valid = 1'b0;
    bus.byte_ready = 1'b1;
    pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'hFF; pay[3] = 8'h00;

    do_reset();

    // Flat calibration: swing too small.
    cf0 = n_cf;
    do_start();
    repeat (CALN) send_sample(8'd100);
    check_val("flat_cal_fail", 32'(n_cf - cf0), 32'd1);
    check_val("flat_thr", 32'(bus.thr_out), 32'd128);
    check_val("flat_state", 32'(bus.state_out), 32'd0);

    cf0 = n_cf;
    cal_standard();
    check_val("cal_thr", 32'(bus.thr_out), 32'd110);
    check_val("cal_state", 32'(bus.state_out), 32'd2);
    check_val("cal_no_fail", 32'(n_cf - cf0), 32'd0);

    do_start();
    check_val("start_ignored", 32'(bus.state_out), 32'd2);

    // Directed frame with consumer always ready.
    ready_mode = 1; bus.byte_ready = 1'b1;
    fd0 = n_fd;
    repeat (3) send_bit(1'b0);
    send_byte(SYNC);
    check_val("sync_state", 32'(bus.state_out), 32'd3);
    for (int i = 0; i < 4; i++) send_byte(pay[i]);
    idle_cycles(2);
    check_val("frame_done_cnt", 32'(n_fd - fd0), 32'd1);
    check_val("frame_state", 32'(bus.state_out), 32'd2);
    check_val("frame_drained", 32'(exp_q.size()), 32'd0);

    // Consumer stalled for a whole frame.
    ready_mode = 0; bus.byte_ready = 1'b0;
    fd0 = n_fd; ov0 = n_ov;
    send_bit(1'b0);
    send_byte(SYNC);
    for (int i = 0; i < 4; i++) send_byte(pay[i]);
    check_val("ovr_held_data", 32'(bus.byte_data), 32'hA5);
    check_val("ovr_count", 32'(n_ov - ov0), 32'd3);
    check_val("ovr_frame_done", 32'(n_fd - fd0), 32'd1);
    ready_mode = 1; bus.byte_ready = 1'b1;
    idle_cycles(2);
    check_val("ovr_drained", 32'(exp_q.size()), 32'd0);

    // Random frames, random ready, ambiguous windows in the prefix.
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      repeat ($urandom_range(0, 6)) send_window($urandom_range(0, 3));
      send_byte(SYNC);
      for (int i = 0; i < FB; i++) send_byte(8'($urandom));
      repeat ($urandom_range(0, 3)) send_bit(1'b0);
    end
    ready_mode = 1; bus.byte_ready = 1'b1;
    idle_cycles(3);
    check_val("rand_drained", 32'(exp_q.size()), 32'd0);

    // Abort in the middle of a frame.
    do_abort();
    cal_standard();
    send_bit(1'b0);
    send_byte(SYNC);
    send_byte(8'($urandom));
    send_byte(8'($urandom));
    repeat (3) send_bit(1'($urandom_range(0, 1)));
    idle_cycles(2);
    ready_mode = 0; bus.byte_ready = 1'b0;
    do_abort();
    check_val("abort_state", 32'(bus.state_out), 32'd0);
    check_val("abort_valid", 32'(bus.byte_valid), 32'd0);
    check_val("abort_thr", 32'(bus.thr_out), 32'd110);
    ready_mode = 1; bus.byte_ready = 1'b1;

    // Random calibrations including the swing boundary either side.
    for (int t = 0; t < 6; t++) begin
      kind = t % 3;
      mn = $urandom_range(0, 200);
      mx = (kind == 0) ? mn + 2 * HYST : (kind == 1) ? mn + 2 * HYST + 1 : $urandom_range(mn, 255);
      for (int i = 0; i < CALN; i++) cal_s[i] = 8'($urandom_range(mn, mx));
      p1 = $urandom_range(0, CALN - 1);
      p2 = (p1 + 1 + $urandom_range(0, CALN - 2)) % CALN;
      cal_s[p1] = 8'(mn);
      cal_s[p2] = 8'(mx);
      cf0 = n_cf;
      do_start();
      for (int i = 0; i < CALN; i++) send_sample(cal_s[i]);
      if (kind == 0) check_val("cal_boundary_fail", 32'(n_cf - cf0), 32'd1);
      if (kind == 1) check_val("cal_boundary_pass", 32'(n_cf - cf0), 32'd0);
      if (model_st != 0) do_abort();
    end

    // Reset in the middle of calibration.
    do_start();
    repeat (40) send_sample(8'($urandom));
    do_reset();
    check_val("final_valid", 32'(bus.byte_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached at %0t", $time);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
